mem_control: RTL and testbench
==============================

Name: mem_control

Overview:
- Memory controller directly downstream of the CPU core.
- Consumes the core's instruction-fetch address and enable, plus its MEM-stage data address, write data, read enable and write enable.
- Serialises both onto a single shared asynchronous SRAM (code and data in one space) and a memory-mapped UART port.
- Returns the instruction word, the data word and the pipeline pause request to the core.

Parameters:
- DATA_W, 16, word width of CPU and SRAM.
- ADDR_W, 16, CPU word-address width.
- SRAM_ADDR_W, 18, SRAM address width; CPU address is zero-extended.
- ACCESS_CYCLES, 2, cycles each SRAM access is held (minimum 2).
- UART_DATA_ADDR, 16'hBF00, UART data register.
- UART_STAT_ADDR, 16'hBF01, UART status register.
- NOP_INST, 16'h0800, instruction word presented at reset.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- inst_addr_i  in  ADDR_W  fetch address (PC).
- inst_en_i  in  1  fetch enable.
- inst_data_o  out  DATA_W  fetched instruction.
- mem_addr_i  in  ADDR_W  data address.
- mem_wdata_i  in  DATA_W  store data.
- mem_rd_i  in  1  load request.
- mem_wr_i  in  1  store request.
- mem_rdata_o  out  DATA_W  load result.
- pause_o  out  1  core must stall.
- sram_addr_o  out  SRAM_ADDR_W  SRAM address.
- sram_wdata_o  out  DATA_W  SRAM write data.
- sram_rdata_i  in  DATA_W  SRAM read data.
- sram_data_oe_o  out  1  drive SRAM data bus.
- sram_ce_n_o, sram_oe_n_o, sram_we_n_o  out  1 each  SRAM strobes, active low.
- uart_tx_data_o  out  8  byte to transmit.
- uart_tx_valid_o  out  1  one-cycle transmit strobe.
- uart_tx_ready_i  in  1  transmitter idle.
- uart_rx_data_i  in  8  received byte.
- uart_rx_valid_i  in  1  byte available.
- uart_rx_ack_o  out  1  one-cycle consume strobe.

Behaviour:
- Reset (rst low, asynchronous), all outputs:
  - state IDLE, counter 0.
  - inst_data_o=NOP_INST, mem_rdata_o=0, pause_o=0.
  - sram_ce_n_o, sram_oe_n_o, sram_we_n_o = 1; sram_data_oe_o=0; sram_addr_o=0; sram_wdata_o=0.
  - uart_tx_valid_o=0, uart_rx_ack_o=0, uart_tx_data_o=0.
  - Reset mid-access aborts immediately; strobes deassert asynchronously.
- FSM states: IDLE, D_ACC, I_ACC, DONE.
- IDLE:
  - inst_en_i=0: stay in IDLE, pause_o=0.
  - inst_en_i=1: pause_o=1.
    - SRAM data request pending (rd/wr, address outside 0xBF00-0xBF0F): go to D_ACC.
    - Otherwise: perform any I/O action this cycle, then go to I_ACC.
- I/O actions, all completed within the IDLE cycle:
  - Write UART_DATA_ADDR: uart_tx_data_o=mem_wdata_i[7:0], uart_tx_valid_o pulses one cycle. A write while tx not ready is dropped; software polls status first.
  - Read UART_DATA_ADDR: mem_rdata_o <= {8'h00, uart_rx_data_i}, uart_rx_ack_o pulses one cycle.
  - Read UART_STAT_ADDR: mem_rdata_o <= {14'b0, uart_rx_valid_i, uart_tx_ready_i}.
  - Other 0xBF0x addresses: reads return 0, writes are ignored.
- D_ACC and I_ACC:
  - Each lasts exactly ACCESS_CYCLES cycles.
  - sram_addr_o is zero-extended mem_addr_i or inst_addr_i respectively; ce_n=0.
  - Read: oe_n=0. The SRAM word is latched into mem_rdata_o or inst_data_o on the last cycle.
  - Write (D_ACC only): sram_data_oe_o=1 and sram_wdata_o stable for the whole access; we_n=0 for all but the last cycle; oe_n=1.
  - D_ACC always proceeds to I_ACC; I_ACC proceeds to DONE. pause_o=1 throughout.
- DONE:
  - pause_o=0; the core advances on this edge using the registered outputs.
  - All strobes high. Next state IDLE.
- Latency, measured from IDLE to the DONE cycle:
  - Fetch only, or fetch with I/O: 1+N+1 cycles (4 at N=2).
  - Fetch with SRAM data access: 1+2N+1 cycles (6 at N=2).
- Upstream rule: the core holds all request inputs stable while pause_o=1.
- Conflicts:
  - mem_rd_i and mem_wr_i together: the write wins and mem_rdata_o is unchanged.
  - inst_en_i is sampled only in IDLE.
- mem_rdata_o and inst_data_o hold their value until overwritten.

Decomposition:
- Shared defines/package entries: bus widths (RegBus, MemAddrBus), NOP encoding, UART addresses, FSM state encodings.
- Natural sub-module: mem_uart_port, the address decode plus UART register read/strobe logic. SRAM sequencing stays in mem_control.

Test Plan:
- Reset, then SRAM[0x0000]=0x4801 and inst_en_i=1, inst_addr_i=0x0000 → pause_o high for 3 cycles, then inst_data_o=0x4801 with pause_o=0 in cycle 4; no we_n assertion.
- Store mem_addr_i=0x8000, mem_wdata_i=0xA5A5, with fetch at 0x0001 → we_n low exactly 1 cycle while sram_addr_o=0x08000 and data_oe=1; DONE at cycle 6; a later load of 0x8000 returns 0xA5A5.
- Load 0xBF01 with uart_rx_valid_i=1, uart_tx_ready_i=0 → mem_rdata_o=0x0002, no SRAM data access, DONE at cycle 4.
- Store 0xBF00, data 0x1241 → uart_tx_valid_o one pulse with uart_tx_data_o=0x41; then load 0xBF00 with rx byte 0x5A → mem_rdata_o=0x005A and uart_rx_ack_o one pulse.
- Assert rst low in the middle of D_ACC (write) → strobes high and data_oe=0 immediately; after release, state is IDLE and inst_data_o=0x0800.
- mem_rd_i=1 and mem_wr_i=1 together at 0x8001, data 0x1234 → SRAM is written, mem_rdata_o unchanged; inst_en_i=0 → pause_o stays 0 and no strobes are asserted.

Source files
------------

// File: rtl/mem_control_pkg.sv
// rtl/mem_control_pkg.sv - shared widths, addresses and FSM encoding for mem_control
package mem_control_pkg;

    localparam int DATA_W        = 16;
    localparam int ADDR_W        = 16;
    localparam int SRAM_ADDR_W   = 18;
    localparam int ACCESS_CYCLES = 2;

    localparam logic [15:0] UART_DATA_ADDR = 16'hBF00;
    localparam logic [15:0] UART_STAT_ADDR = 16'hBF01;
    localparam logic [15:0] NOP_INST       = 16'h0800;

    typedef logic [DATA_W-1:0] reg_bus_t;
    typedef logic [ADDR_W-1:0] mem_addr_bus_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_D_ACC = 2'd1,
        ST_I_ACC = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/mem_control_if.sv
// rtl/mem_control_if.sv - core-side fetch/load/store bus of mem_control
interface mem_control_if #(
    parameter int DATA_W = mem_control_pkg::DATA_W,
    parameter int ADDR_W = mem_control_pkg::ADDR_W
);
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_en;
    logic [DATA_W-1:0] inst_data;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_rdata;
    logic              pause;

    modport master (
        output inst_addr, inst_en, mem_addr, mem_wdata, mem_rd, mem_wr,
        input  inst_data, mem_rdata, pause
    );

    modport slave (
        input  inst_addr, inst_en, mem_addr, mem_wdata, mem_rd, mem_wr,
        output inst_data, mem_rdata, pause
    );
endinterface

// File: rtl/mem_uart_port.sv
// rtl/mem_uart_port.sv - I/O window decode plus UART register read and strobe logic
module mem_uart_port #(
    parameter int                DATA_W         = 16,
    parameter int                ADDR_W         = 16,
    parameter logic [ADDR_W-1:0] UART_DATA_ADDR = 16'hBF00,
    parameter logic [ADDR_W-1:0] UART_STAT_ADDR = 16'hBF01
) (
    input  logic              act_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [7:0]        wbyte_i,
    input  logic              rd_i,
    input  logic              wr_i,
    output logic              is_io_o,
    output logic              load_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ack_o
);

    always_comb begin
        is_io_o    = (addr_i[ADDR_W-1:4] == UART_DATA_ADDR[ADDR_W-1:4]);
        load_o     = 1'b0;
        rdata_o    = '0;
        tx_data_o  = 8'h00;
        tx_valid_o = 1'b0;
        rx_ack_o   = 1'b0;
        if (act_i && is_io_o) begin
            // A store takes priority over a simultaneous load.
            if (wr_i) begin
                if (addr_i == UART_DATA_ADDR && tx_ready_i) begin
                    tx_valid_o = 1'b1;
                    tx_data_o  = wbyte_i;
                end
            end else if (rd_i) begin
                load_o = 1'b1;
                if (addr_i == UART_DATA_ADDR) begin
                    rdata_o[7:0] = rx_data_i;
                    rx_ack_o     = 1'b1;
                end else if (addr_i == UART_STAT_ADDR) begin
                    rdata_o[1:0] = {rx_valid_i, tx_ready_i};
                end
            end
        end
    end

endmodule

// File: rtl/mem_control.sv
// rtl/mem_control.sv - serialises core fetch and data accesses onto one async SRAM plus UART
module mem_control
    import mem_control_pkg::*;
#(
    parameter int                DATA_W         = mem_control_pkg::DATA_W,
    parameter int                ADDR_W         = mem_control_pkg::ADDR_W,
    parameter int                SRAM_ADDR_W    = mem_control_pkg::SRAM_ADDR_W,
    parameter int                ACCESS_CYCLES  = mem_control_pkg::ACCESS_CYCLES,
    parameter logic [ADDR_W-1:0] UART_DATA_ADDR = mem_control_pkg::UART_DATA_ADDR,
    parameter logic [ADDR_W-1:0] UART_STAT_ADDR = mem_control_pkg::UART_STAT_ADDR,
    parameter logic [DATA_W-1:0] NOP_INST       = mem_control_pkg::NOP_INST
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_control_if.slave           core,
    output logic [SRAM_ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0]      sram_wdata_o,
    input  logic [DATA_W-1:0]      sram_rdata_i,
    output logic                   sram_data_oe_o,
    output logic                   sram_ce_n_o,
    output logic                   sram_oe_n_o,
    output logic                   sram_we_n_o,
    output logic [7:0]             uart_tx_data_o,
    output logic                   uart_tx_valid_o,
    input  logic                   uart_tx_ready_i,
    input  logic [7:0]             uart_rx_data_i,
    input  logic                   uart_rx_valid_i,
    output logic                   uart_rx_ack_o
);

    localparam int             CNT_W    = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] inst_data_q, inst_data_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

    logic              act;
    logic              last;
    logic              is_io;
    logic              io_load;
    logic [DATA_W-1:0] io_rdata;
    logic              data_req;
    logic              load_only;

    // rst gates the combinational IDLE outputs so they read inactive while held in reset.
    assign act       = rst && (state_q == ST_IDLE) && core.inst_en;
    assign last      = (cnt_q == CNT_LAST);
    assign data_req  = (core.mem_rd || core.mem_wr) && !is_io;
    assign load_only = core.mem_rd && !core.mem_wr;

    mem_uart_port #(
        .DATA_W         (DATA_W),
        .ADDR_W         (ADDR_W),
        .UART_DATA_ADDR (UART_DATA_ADDR),
        .UART_STAT_ADDR (UART_STAT_ADDR)
    ) u_uart_port (
        .act_i      (act),
        .addr_i     (core.mem_addr),
        .wbyte_i    (core.mem_wdata[7:0]),
        .rd_i       (core.mem_rd),
        .wr_i       (core.mem_wr),
        .is_io_o    (is_io),
        .load_o     (io_load),
        .rdata_o    (io_rdata),
        .tx_data_o  (uart_tx_data_o),
        .tx_valid_o (uart_tx_valid_o),
        .tx_ready_i (uart_tx_ready_i),
        .rx_data_i  (uart_rx_data_i),
        .rx_valid_i (uart_rx_valid_i),
        .rx_ack_o   (uart_rx_ack_o)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            inst_data_q <= NOP_INST;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            inst_data_q <= inst_data_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        inst_data_d = inst_data_q;
        mem_rdata_d = mem_rdata_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (act) begin
                    state_d = data_req ? ST_D_ACC : ST_I_ACC;
                    if (io_load) mem_rdata_d = io_rdata;
                end
            end
            ST_D_ACC: begin
                if (last) begin
                    state_d = ST_I_ACC;
                    cnt_d   = '0;
                    if (load_only) mem_rdata_d = sram_rdata_i;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_I_ACC: begin
                if (last) begin
                    state_d     = ST_DONE;
                    cnt_d       = '0;
                    inst_data_d = sram_rdata_i;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes decode straight from the state register so an async reset drops them at once.
    always_comb begin
        sram_addr_o    = '0;
        sram_wdata_o   = '0;
        sram_data_oe_o = 1'b0;
        sram_ce_n_o    = 1'b1;
        sram_oe_n_o    = 1'b1;
        sram_we_n_o    = 1'b1;
        core.pause     = 1'b0;
        case (state_q)
            ST_IDLE: core.pause = act;
            ST_D_ACC: begin
                core.pause  = 1'b1;
                sram_ce_n_o = 1'b0;
                sram_addr_o = SRAM_ADDR_W'(core.mem_addr);
                if (core.mem_wr) begin
                    sram_data_oe_o = 1'b1;
                    sram_wdata_o   = core.mem_wdata;
                    sram_we_n_o    = last;
                end else begin
                    sram_oe_n_o = 1'b0;
                end
            end
            ST_I_ACC: begin
                core.pause  = 1'b1;
                sram_ce_n_o = 1'b0;
                sram_oe_n_o = 1'b0;
                sram_addr_o = SRAM_ADDR_W'(core.inst_addr);
            end
            default: ;
        endcase
    end

    assign core.inst_data = inst_data_q;
    assign core.mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_control.sv
// tb/tb_mem_control.sv - directed scoreboard bench for mem_control
module tb_mem_control;
    import mem_control_pkg::*;

    logic        clk;
    logic        rst;
    logic [17:0] sram_addr_o;
    logic [15:0] sram_wdata_o;
    logic [15:0] sram_rdata_i;
    logic        sram_data_oe_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o;
    logic [7:0]  uart_tx_data_o;
    logic        uart_tx_valid_o;
    logic        uart_tx_ready_i;
    logic [7:0]  uart_rx_data_i;
    logic        uart_rx_valid_i;
    logic        uart_rx_ack_o;

    logic [15:0] sram_mem [0:262143];
    logic        bd_we;
    logic [17:0] bd_addr;
    logic [15:0] bd_data;

    int total;
    int bad;

    typedef struct {
        logic [15:0] inst;
        logic [15:0] rdata;
        int          lat;
        int          we;
        int          tx;
        logic [7:0]  txd;
        int          ack;
        int          dacc;
    } exp_t;

    exp_t sb[$];

    mem_control_if bus ();

    mem_control dut (
        .clk             (clk),
        .rst             (rst),
        .core            (bus.slave),
        .sram_addr_o     (sram_addr_o),
        .sram_wdata_o    (sram_wdata_o),
        .sram_rdata_i    (sram_rdata_i),
        .sram_data_oe_o  (sram_data_oe_o),
        .sram_ce_n_o     (sram_ce_n_o),
        .sram_oe_n_o     (sram_oe_n_o),
        .sram_we_n_o     (sram_we_n_o),
        .uart_tx_data_o  (uart_tx_data_o),
        .uart_tx_valid_o (uart_tx_valid_o),
        .uart_tx_ready_i (uart_tx_ready_i),
        .uart_rx_data_i  (uart_rx_data_i),
        .uart_rx_valid_i (uart_rx_valid_i),
        .uart_rx_ack_o   (uart_rx_ack_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sram_rdata_i = (!sram_ce_n_o && !sram_oe_n_o) ? sram_mem[sram_addr_o] : 16'hDEAD;

    always @(negedge clk) begin
        if (bd_we)
            sram_mem[bd_addr] <= bd_data;
        else if (!sram_ce_n_o && !sram_we_n_o && sram_data_oe_o)
            sram_mem[sram_addr_o] <= sram_wdata_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [17:0] a, input logic [15:0] d);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        @(negedge clk);
        #1 bd_we = 1'b0;
    endtask

    function automatic exp_t mk(input logic [15:0] inst, input logic [15:0] rdata, input int lat,
                                input int we, input int tx, input logic [7:0] txd, input int ack,
                                input int dacc);
        exp_t e;
        e.inst = inst; e.rdata = rdata; e.lat = lat; e.we = we;
        e.tx = tx; e.txd = txd; e.ack = ack; e.dacc = dacc;
        return e;
    endfunction

    task automatic run_access(input string tag, input logic [15:0] ia, input logic rd,
                              input logic wr, input logic [15:0] ma, input logic [15:0] wd,
                              input exp_t e);
        exp_t got;
        int lat, we, tx, ack, dacc, weok, done;
        logic [7:0] txd;
        sb.push_back(e);
        bus.inst_addr = ia;
        bus.inst_en   = 1'b1;
        bus.mem_addr  = ma;
        bus.mem_wdata = wd;
        bus.mem_rd    = rd;
        bus.mem_wr    = wr;
        lat = 0; we = 0; tx = 0; ack = 0; dacc = 0; weok = 1; done = 0; txd = 8'h00;
        for (int c = 1; c <= 20 && done == 0; c++) begin
            @(negedge clk);
            if (!sram_we_n_o) begin
                we++;
                if (sram_addr_o != {2'b00, ma} || !sram_data_oe_o) weok = 0;
            end
            if (uart_tx_valid_o) begin
                tx++;
                txd = uart_tx_data_o;
            end
            if (uart_rx_ack_o) ack++;
            if (!sram_ce_n_o && sram_addr_o != {2'b00, ia}) dacc = 1;
            if (!bus.pause) begin
                done = 1;
                lat  = c;
            end
        end
        got = sb.pop_front();
        check({tag, "_done"}, done, 1);
        check({tag, "_lat"}, lat, got.lat);
        check({tag, "_inst"}, bus.inst_data, got.inst);
        check({tag, "_rdata"}, bus.mem_rdata, got.rdata);
        check({tag, "_we"}, we, got.we);
        check({tag, "_weaddr"}, weok, 1);
        check({tag, "_tx"}, tx, got.tx);
        if (got.tx > 0) check({tag, "_txd"}, txd, got.txd);
        check({tag, "_ack"}, ack, got.ack);
        check({tag, "_dacc"}, dacc, got.dacc);
        @(posedge clk);
        #1;
        bus.inst_en = 1'b0;
        bus.mem_rd  = 1'b0;
        bus.mem_wr  = 1'b0;
    endtask

    initial begin
        int seen;
        total = 0;
        bad   = 0;
        rst = 1'b0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        bus.inst_addr = '0; bus.inst_en = 1'b0; bus.mem_addr = '0;
        bus.mem_wdata = '0; bus.mem_rd = 1'b0; bus.mem_wr = 1'b0;
        uart_tx_ready_i = 1'b0; uart_rx_data_i = 8'h00; uart_rx_valid_i = 1'b0;

        preload(18'h00000, 16'h4801);
        preload(18'h00001, 16'h1111);
        preload(18'h00002, 16'h2222);
        preload(18'h00003, 16'h3333);

        @(negedge clk);
        check("rst_inst", bus.inst_data, 16'h0800);
        check("rst_rdata", bus.mem_rdata, 16'h0000);
        check("rst_pause", bus.pause, 1'b0);
        check("rst_strobes", {sram_ce_n_o, sram_oe_n_o, sram_we_n_o}, 3'b111);
        check("rst_doe", sram_data_oe_o, 1'b0);
        check("rst_addr", sram_addr_o, 18'h0);
        check("rst_wdata", sram_wdata_o, 16'h0);
        check("rst_uart", {uart_tx_valid_o, uart_rx_ack_o, uart_tx_data_o}, 10'h0);

        @(posedge clk);
        #1 rst = 1'b1;

        run_access("fetch0", 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
                   mk(16'h4801, 16'h0000, 4, 0, 0, 8'h00, 0, 0));
        run_access("store8000", 16'h0001, 1'b0, 1'b1, 16'h8000, 16'hA5A5,
                   mk(16'h1111, 16'h0000, 6, 1, 0, 8'h00, 0, 1));
        run_access("load8000", 16'h0002, 1'b1, 1'b0, 16'h8000, 16'h0000,
                   mk(16'h2222, 16'hA5A5, 6, 0, 0, 8'h00, 0, 1));

        uart_rx_valid_i = 1'b1; uart_tx_ready_i = 1'b0;
        run_access("stat", 16'h0003, 1'b1, 1'b0, 16'hBF01, 16'h0000,
                   mk(16'h3333, 16'h0002, 4, 0, 0, 8'h00, 0, 0));

        uart_tx_ready_i = 1'b1;
        run_access("txbyte", 16'h0000, 1'b0, 1'b1, 16'hBF00, 16'h1241,
                   mk(16'h4801, 16'h0002, 4, 0, 1, 8'h41, 0, 0));

        uart_rx_data_i = 8'h5A;
        run_access("rxbyte", 16'h0001, 1'b1, 1'b0, 16'hBF00, 16'h0000,
                   mk(16'h1111, 16'h005A, 4, 0, 0, 8'h00, 1, 0));

        uart_tx_ready_i = 1'b0;
        run_access("txdrop", 16'h0002, 1'b0, 1'b1, 16'hBF00, 16'h0077,
                   mk(16'h2222, 16'h005A, 4, 0, 0, 8'h00, 0, 0));

        run_access("rdwr", 16'h0003, 1'b1, 1'b1, 16'h8001, 16'h1234,
                   mk(16'h3333, 16'h005A, 6, 1, 0, 8'h00, 0, 1));
        run_access("load8001", 16'h0000, 1'b1, 1'b0, 16'h8001, 16'h0000,
                   mk(16'h4801, 16'h1234, 6, 0, 0, 8'h00, 0, 1));
        run_access("io_other", 16'h0001, 1'b1, 1'b0, 16'hBF05, 16'h0000,
                   mk(16'h1111, 16'h0000, 4, 0, 0, 8'h00, 0, 0));

        bus.inst_en = 1'b0; bus.mem_rd = 1'b1; bus.mem_addr = 16'h8000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("noen_pause", bus.pause, 1'b0);
            check("noen_ce", sram_ce_n_o, 1'b1);
        end
        bus.mem_rd = 1'b0;

        @(posedge clk);
        #1;
        bus.inst_addr = 16'h0000; bus.inst_en = 1'b1;
        bus.mem_addr = 16'h8002; bus.mem_wdata = 16'hBEEF; bus.mem_wr = 1'b1;
        seen = 0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            @(negedge clk);
            if (!sram_we_n_o) seen = 1;
        end
        check("abort_we_seen", seen, 1);
        rst = 1'b0;
        #1;
        check("abort_strobes", {sram_ce_n_o, sram_oe_n_o, sram_we_n_o}, 3'b111);
        check("abort_doe", sram_data_oe_o, 1'b0);
        check("abort_pause", bus.pause, 1'b0);
        check("abort_inst", bus.inst_data, 16'h0800);
        check("abort_rdata", bus.mem_rdata, 16'h0000);
        bus.inst_en = 1'b0; bus.mem_wr = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("post_rst_pause", bus.pause, 1'b0);
        check("post_rst_inst", bus.inst_data, 16'h0800);
        @(posedge clk);
        #1;
        run_access("post_rst_fetch", 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
                   mk(16'h4801, 16'h0000, 4, 0, 0, 8'h00, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
